operand_link_tx: RTL and testbench

//  Transmit end of the CHORD operand link: the host-side block that drives what interface_input receives.

---
 rtl/operand_link_tx.sv | 175 +++++++++++++++++
 tb/tb_operand_link_tx.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_link_tx.sv
// Transmit end of the CHORD operand link: FIFO-buffered (x,y) pairs serialised as SYNC, x, y[, checksum].
// Build option: define OPERAND_TX_CHECKSUM_EN to append an XOR checksum byte to every frame.
module operand_link_tx #(
   parameter int         INPUT_WIDTH = 16,
   parameter int         FIFO_DEPTH  = 4,
   parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [INPUT_WIDTH-1:0] in_x,
   input  logic [INPUT_WIDTH-1:0] in_y,
   output logic                   link_valid,
   input  logic                   link_ready,
   output logic [7:0]             link_data,
   output logic                   link_sof,
   output logic                   link_eof,
   output logic                   busy,
   output logic [15:0]            frame_count
);

   localparam int B  = INPUT_WIDTH / 8;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int IW = (B > 1) ? $clog2(B) : 1;
   localparam logic [IW-1:0] LAST    = IW'(B - 1);
   localparam logic [IW-1:0] IDX_ONE = IW'(1);
   localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);
`ifdef OPERAND_TX_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      XB,
      YB
`ifdef OPERAND_TX_CHECKSUM_EN
      , CSUM
`endif
   } state_t;

   state_t                         state;
   logic [IW-1:0]                  idx;
   logic [2*INPUT_WIDTH-1:0]       mem [FIFO_DEPTH];
   logic [AW:0]                    wr_ptr;
   logic [AW:0]                    rd_ptr;
   logic signed [INPUT_WIDTH-1:0]  frame_x;
   logic signed [INPUT_WIDTH-1:0]  frame_y;
`ifdef OPERAND_TX_CHECKSUM_EN
   logic [7:0]                     csum;
`endif
   logic fifo_empty;
   logic fifo_full;
   logic push;
   logic pop;
   logic xfer;

   function automatic logic [7:0] byte_of(input logic [INPUT_WIDTH-1:0] v, input int k);
      logic [INPUT_WIDTH-1:0] s;
      s = v >> (8 * (B - 1 - k));
      return s[7:0];
   endfunction

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign in_ready   = !fifo_full;
   assign push       = in_valid && in_ready;
   assign pop        = (state == IDLE) && !fifo_empty;
   assign xfer       = link_valid && link_ready;
   assign busy       = (state != IDLE) || !fifo_empty;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= {in_x, in_y};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Frame register: holds the pair being serialised, freeing its FIFO slot.
   always_ff @(posedge clk) begin
      if (pop) {frame_x, frame_y} <= mem[rd_ptr[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= '0;
         link_valid  <= 1'b0;
         link_data   <= '0;
         link_sof    <= 1'b0;
         link_eof    <= 1'b0;
         frame_count <= '0;
`ifdef OPERAND_TX_CHECKSUM_EN
         csum        <= '0;
`endif
      end else begin
         if (xfer && link_eof) frame_count <= frame_count + 16'd1;
         case (state)
            IDLE: if (!fifo_empty) begin
               state      <= SYNC;
               idx        <= '0;
               link_valid <= 1'b1;
               link_data  <= SYNC_BYTE;
               link_sof   <= 1'b1;
               link_eof   <= 1'b0;
`ifdef OPERAND_TX_CHECKSUM_EN
               csum       <= '0;
`endif
            end
            SYNC: if (xfer) begin
               state     <= XB;
               idx       <= '0;
               link_sof  <= 1'b0;
               link_data <= byte_of(frame_x, 0);
            end
            XB: if (xfer) begin
`ifdef OPERAND_TX_CHECKSUM_EN
               csum <= csum ^ link_data;
`endif
               if (idx == LAST) begin
                  state     <= YB;
                  idx       <= '0;
                  link_data <= byte_of(frame_y, 0);
                  link_eof  <= (B == 1) && !CSUM_EN;
               end else begin
                  idx       <= idx + IDX_ONE;
                  link_data <= byte_of(frame_x, int'(idx) + 1);
               end
            end
            YB: if (xfer) begin
               if (idx == LAST) begin
`ifdef OPERAND_TX_CHECKSUM_EN
                  // Running XOR excludes the byte now leaving, so fold it in here.
                  state     <= CSUM;
                  link_data <= csum ^ link_data;
                  link_eof  <= 1'b1;
`else
                  state      <= IDLE;
                  link_valid <= 1'b0;
                  link_data  <= '0;
                  link_eof   <= 1'b0;
`endif
               end else begin
`ifdef OPERAND_TX_CHECKSUM_EN
                  csum      <= csum ^ link_data;
`endif
                  idx       <= idx + IDX_ONE;
                  link_data <= byte_of(frame_y, int'(idx) + 1);
                  link_eof  <= (int'(idx) + 2 == B) && !CSUM_EN;
               end
            end
`ifdef OPERAND_TX_CHECKSUM_EN
            CSUM: if (xfer) begin
               state      <= IDLE;
               link_valid <= 1'b0;
               link_data  <= '0;
               link_eof   <= 1'b0;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_operand_link_tx.sv
// Self-checking bench for operand_link_tx: frame tables, corner sequences and a random run against a byte-queue model.
module tb_operand_link_tx;

   localparam int B = 2;
`ifdef OPERAND_TX_CHECKSUM_EN
   localparam int NB = 2 * B + 2;
   localparam bit CS = 1'b1;
`else
   localparam int NB = 2 * B + 1;
   localparam bit CS = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_x;
   logic [15:0] in_y;
   logic        link_valid;
   logic        link_ready;
   logic [7:0]  link_data;
   logic        link_sof;
   logic        link_eof;
   logic        busy;
   logic [15:0] frame_count;

   operand_link_tx dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .link_valid(link_valid), .link_ready(link_ready),
      .link_data(link_data), .link_sof(link_sof), .link_eof(link_eof),
      .busy(busy), .frame_count(frame_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] d;
      logic       sof;
      logic       eof;
   } lbyte_t;

   typedef struct {
      logic [15:0] x;
      logic [15:0] y;
      logic [47:0] b;
   } vec_t;

   lbyte_t exp_q [$];
   lbyte_t cap_q [$];
   lbyte_t hold;
   logic   stall_prev;
   int     checks;
   int     errors;
   int     n_push;

   function automatic void model_push(input logic [15:0] x, input logic [15:0] y);
      logic [7:0] pay [$];
      logic [7:0] cs;
      cs = 8'h00;
      for (int k = 0; k < B; k++) pay.push_back(8'(x >> (8 * (B - 1 - k))));
      for (int k = 0; k < B; k++) pay.push_back(8'(y >> (8 * (B - 1 - k))));
      exp_q.push_back('{d: 8'hA5, sof: 1'b1, eof: 1'b0});
      foreach (pay[k]) begin
         cs ^= pay[k];
         exp_q.push_back('{d: pay[k], sof: 1'b0, eof: (!CS && (k == pay.size() - 1))});
      end
      if (CS) exp_q.push_back('{d: cs, sof: 1'b0, eof: 1'b1});
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Link monitor: model order, byte content and backpressure stability.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            checks++;
            if (!link_valid || link_data !== hold.d || link_sof !== hold.sof || link_eof !== hold.eof) begin
               errors++;
               $display("FAIL stall_hold: got v=%b d=%h sof=%b eof=%b expected d=%h sof=%b eof=%b",
                        link_valid, link_data, link_sof, link_eof, hold.d, hold.sof, hold.eof);
            end
         end
         stall_prev = link_valid && !link_ready;
         hold = '{d: link_data, sof: link_sof, eof: link_eof};
         if (link_valid && link_ready) begin
            cap_q.push_back(hold);
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL model_byte: got unexpected byte %h expected none", link_data);
            end else begin
               lbyte_t e;
               e = exp_q.pop_front();
               if (e !== hold) begin
                  errors++;
                  $display("FAIL model_byte: got d=%h sof=%b eof=%b expected d=%h sof=%b eof=%b",
                           hold.d, hold.sof, hold.eof, e.d, e.sof, e.eof);
               end
            end
         end
         if (in_valid && in_ready) begin
            model_push(in_x, in_y);
            n_push++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n;
      n = 0;
      while ((busy || link_valid) && n < budget) begin
         tick();
         n++;
      end
      chk({name, "_idle_timeout"}, {30'd0, busy, link_valid}, 32'd0);
   endtask

   task automatic push_pair(input logic [15:0] x, input logic [15:0] y);
      in_valid = 1'b1;
      in_x     = x;
      in_y     = y;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   vec_t        tbl [4];
   int          vcount;
   int          gaps;
   int          np0;
   logic [15:0] fc0;
   logic [15:0] y0;
   logic        seen_valid;

   initial begin
      checks = 0; errors = 0; n_push = 0; stall_prev = 1'b0;
      rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; link_ready = 1'b1;
      tbl[0] = '{16'h0100, 16'h0080, 48'hA5_01_00_00_80_81};
      tbl[1] = '{16'hFFFF, 16'h8000, 48'hA5_FF_FF_80_00_80};
      tbl[2] = '{16'h1234, 16'h5678, 48'hA5_12_34_56_78_08};
      tbl[3] = '{16'h00FF, 16'hFF00, 48'hA5_00_FF_FF_00_00};
      tick(); tick(); tick();
      rst = 1'b0;
      chk("rst_link_valid", link_valid, 0);
      chk("rst_sof_eof", {link_sof, link_eof}, 0);
      chk("rst_link_data", link_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_frame_count", frame_count, 0);

      // Table frames: latency, byte sequence, flags, valid-cycle count, frame count.
      for (int i = 0; i < 4; i++) begin
         cap_q.delete();
         push_pair(tbl[i].x, tbl[i].y);
         chk($sformatf("vec%0d_lat_n1", i), link_valid, 0);
         tick();
         chk($sformatf("vec%0d_lat_n2", i), {link_valid, link_sof, link_data}, {2'b11, 8'hA5});
         vcount = 1;
         for (int c = 0; c < 30 && (busy || link_valid); c++) begin
            tick();
            if (link_valid) vcount++;
         end
         chk($sformatf("vec%0d_valid_cycles", i), vcount, NB);
         chk($sformatf("vec%0d_nbytes", i), cap_q.size(), NB);
         for (int k = 0; k < NB && k < cap_q.size(); k++) begin
            logic [47:0] bb;
            bb = tbl[i].b;
            chk($sformatf("vec%0d_byte%0d", i, k), {cap_q[k].d, cap_q[k].sof, cap_q[k].eof},
                {bb[47-8*k -: 8], (k == 0), (k == NB - 1)});
         end
         chk($sformatf("vec%0d_frame_count", i), frame_count, i + 1);
      end

      // Stall while byte 01 is presented.
      push_pair(16'h0100, 16'h0080);
      seen_valid = 1'b0;
      for (int c = 0; c < 20 && !seen_valid; c++) begin
         if (link_valid && link_data == 8'h01 && !link_sof) seen_valid = 1'b1;
         else tick();
      end
      chk("stall_reach_01", seen_valid, 1);
      link_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("stall_hold_%0d", c), {link_valid, link_data}, {1'b1, 8'h01});
      end
      link_ready = 1'b1;
      wait_idle(40, "stall");
      chk("stall_frame_count", frame_count, 5);

      // Randomised traffic with random backpressure.
      fc0 = frame_count;
      np0 = n_push;
      for (int c = 0; c < 600; c++) begin
         in_valid   = ($urandom_range(0, 2) == 0);
         in_x       = 16'($urandom);
         in_y       = 16'($urandom);
         link_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      in_valid   = 1'b0;
      link_ready = 1'b1;
      wait_idle(400, "rand");
      chk("rand_model_drained", exp_q.size(), 0);
      chk("rand_frame_count", frame_count, 16'(fc0 + 16'(n_push - np0)));

      // Capacity: FIFO_DEPTH + 1 pairs with the link stalled from reset.
      link_ready = 1'b0;
      do_reset();
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("cap_in_ready%0d", k), in_ready, (k < 5));
         in_valid = 1'b1;
         in_x     = 16'(16'h1000 + k);
         in_y     = 16'(16'h2000 + k);
         tick();
      end
      in_valid   = 1'b0;
      link_ready = 1'b1;
      gaps = 0;
      for (int c = 0; c < 200 && (busy || link_valid); c++) begin
         tick();
         if (!link_valid && busy) gaps++;
      end
      chk("cap_idle_gaps", gaps, 4);
      chk("cap_frames", frame_count, 5);
      chk("cap_model_drained", exp_q.size(), 0);

      // Reset during the y MSB byte with two pairs queued.
      link_ready = 1'b0;
      y0 = 16'hC3E1;
      push_pair(16'h7A5B, y0);
      in_valid = 1'b1; in_x = 16'h1111; in_y = 16'h2222; tick();
      in_x = 16'h3333; in_y = 16'h4444; tick();
      in_valid = 1'b0;
      seen_valid = 1'b0;
      for (int c = 0; c < 10 && !seen_valid; c++) begin
         if (link_valid && link_sof) seen_valid = 1'b1;
         else tick();
      end
      chk("abort_sync_seen", seen_valid, 1);
      link_ready = 1'b1;
      for (int c = 0; c < B + 1; c++) tick();
      chk("abort_y_msb", {link_valid, link_data}, {1'b1, y0[15:8]});
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_link_valid", link_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_in_ready", in_ready, 1);
      chk("abort_frame_count", frame_count, 0);
      chk("abort_outputs", {link_sof, link_eof, link_data}, 0);
      seen_valid = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (link_valid) seen_valid = 1'b1;
      end
      chk("abort_no_resume", seen_valid, 0);

      // frame_count wrap.
      force dut.frame_count = 16'hFFFE;
      #2;
      release dut.frame_count;
      chk("wrap_preload", frame_count, 16'hFFFE);
      push_pair(16'h0042, 16'hFF80);
      wait_idle(40, "wrap1");
      chk("wrap_ffff", frame_count, 16'hFFFF);
      push_pair(16'h8001, 16'h0001);
      wait_idle(40, "wrap2");
      chk("wrap_zero", frame_count, 16'h0000);
      chk("final_model_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
